// File: rtl/mult_pkg.sv
// Shared width constants and FSM state encoding for the multiplier datapath
// and the product accumulator that follows it.
package mult_pkg;

  // Default product, accumulator and block-counter widths
  localparam int PW_DEF = 16;
  localparam int AW_DEF = 24;
  localparam int CW_DEF = 8;

  // Accumulator FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_e;

endpackage : mult_pkg

// File: rtl/sat_add_u.sv
// Unsigned saturating adder: sum clamps to all-ones when the true result
// does not fit in W bits, and ovf reports that the clamp happened.
module sat_add_u #(
  parameter int W = 24
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic [W:0] fullSum;

  // Add with one extra carry bit, then clamp on carry-out
  always_comb begin
    fullSum = {1'b0, a} + {1'b0, b};
    ovf     = fullSum[W];
    sum     = fullSum[W] ? {W{1'b1}} : fullSum[W-1:0];
  end

endmodule : sat_add_u

// File: rtl/product_accumulator.sv
// Sums blocks of unsigned products arriving over valid/ready and emits each
// block total, its product count and a sticky saturation flag. A block ends
// when its sampled length is reached or when flush closes it early.
module product_accumulator
  import mult_pkg::*;
#(
  parameter int PW = PW_DEF,
  parameter int AW = AW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_prod,
  input  logic [CW-1:0] len,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_sum,
  output logic [CW:0]   out_cnt,
  output logic          out_ovf
);

  // A length field of zero encodes the largest block, 2**CW products
  localparam logic [CW:0] MAX_LEN = (CW + 1)'(1) << CW;

  acc_state_e  state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [CW:0]   cnt_q, cnt_d;
  logic [CW:0]   len_q, len_d;
  logic          ovf_q, ovf_d;
  logic          in_ready_q;
  logic          out_valid_q;

  logic          beat;
  logic [CW:0]   lenEff;
  logic [CW:0]   cntInc;
  logic [AW-1:0] prodExt;
  logic [AW-1:0] addSum;
  logic          addOvf;

  assign beat    = in_valid & in_ready_q;
  assign lenEff  = (len == '0) ? MAX_LEN : {1'b0, len};
  assign cntInc  = cnt_q + (CW + 1)'(1);
  assign prodExt = AW'(in_prod);

  sat_add_u #(
    .W(AW)
  ) u_sat_add (
    .a  (acc_q),
    .b  (prodExt),
    .sum(addSum),
    .ovf(addOvf)
  );

  // Next-state and datapath update for the block accumulator FSM
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (beat) begin
          len_d   = lenEff;
          acc_d   = prodExt;
          cnt_d   = (CW + 1)'(1);
          ovf_d   = 1'b0;
          state_d = (lenEff == (CW + 1)'(1)) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (beat) begin
          acc_d = addSum;
          ovf_d = ovf_q | addOvf;
          cnt_d = cntInc;
          if ((cntInc == len_q) || flush) begin
            state_d = HOLD;
          end
        end else if (flush) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath registers and registered handshake flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= (state_d != HOLD);
      out_valid_q <= (state_d == HOLD);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = acc_q;
  assign out_cnt   = cnt_q;
  assign out_ovf   = ovf_q;

endmodule : product_accumulator
